bus_arbiter: RTL and testbench

- Central arbiter for the serial system bus. It sits upstream of each module's master port and drives arbitor_busy, bus_busy and approval_grant to them.
- Arbitrates two masters with fixed priority, M1 over M2.
- Deserialises the granted master's serial slave-select and drives the bus mux selects.
- Supports one outstanding split transaction, released when the slave signals split and resumed when the slave clears split_en.

---
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter.sv | 134 +++++++++++++
 tb/tb_bus_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: serial system bus handshake between two masters and the central arbiter
// Ports: requests, serial slave ids, trans_done and per-slave split_en flow into the arbiter;
// grants, busy flags, mux selects and split_pending flow back to the masters.
interface bus_arbiter_if #(
  parameter int SLAVE_LEN  = 2,
  parameter int NUM_SLAVES = 3
);
  logic                  m1_request;
  logic                  m2_request;
  logic                  m1_slave_select;
  logic                  m2_slave_select;
  logic                  m1_trans_done;
  logic                  m2_trans_done;
  logic [NUM_SLAVES-1:0] split_en;
  logic                  m1_approval_grant;
  logic                  m2_approval_grant;
  logic                  arbitor_busy;
  logic                  bus_busy;
  logic                  master_sel;
  logic [SLAVE_LEN-1:0]  slave_sel;
  logic                  split_pending;
  modport slave (
    input  m1_request, m2_request, m1_slave_select, m2_slave_select,
           m1_trans_done, m2_trans_done, split_en,
    output m1_approval_grant, m2_approval_grant, arbitor_busy, bus_busy,
           master_sel, slave_sel, split_pending
  );
  modport master (
    output m1_request, m2_request, m1_slave_select, m2_slave_select,
           m1_trans_done, m2_trans_done, split_en,
    input  m1_approval_grant, m2_approval_grant, arbitor_busy, bus_busy,
           master_sel, slave_sel, split_pending
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: fixed-priority (M1 over M2) serial bus arbiter with one outstanding split transaction
// Ports: clk; reset (synchronous, active low); bus (slave modport) carrying requests, serial
// slave ids, trans_done, split_en in and grants, arbitor_busy, bus_busy, master_sel,
// slave_sel, split_pending out. Every output is a flop loaded from the next-state decode.
module bus_arbiter #(
  parameter int SLAVE_LEN  = 2,
  parameter int NUM_SLAVES = 3
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(SLAVE_LEN + 1);
  typedef enum logic [2:0] {IDLE, GRANT, SELECT, BUSY, RESUME} state_t;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [SLAVE_LEN-1:0]  slave_q, slave_d;
  logic [SLAVE_LEN-1:0]  shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  smaster_q, smaster_d;
  logic [SLAVE_LEN-1:0]  sslave_q, sslave_d;
  logic                  g1_q, g1_d, g2_q, g2_d, ab_q, ab_d, bb_q, bb_d;
  logic                  req, sel_bit, done, bad_id;
  logic [NUM_SLAVES:0]   split_ext;
  logic [SLAVE_LEN:0]    shift_ext;
  logic [SLAVE_LEN-1:0]  id;
  always_comb begin
    req       = owner_q ? bus.m2_request : bus.m1_request;
    sel_bit   = owner_q ? bus.m2_slave_select : bus.m1_slave_select;
    done      = owner_q ? bus.m2_trans_done : bus.m1_trans_done;
    // bit 0 pads id 0 so a slave id indexes its own split_en bit directly
    split_ext = {bus.split_en, 1'b0};
    shift_ext = {shift_q, sel_bit};
    id        = shift_ext[SLAVE_LEN-1:0];
    bad_id    = id == '0 || int'(id) > NUM_SLAVES || (pend_q && id == sslave_q);
    state_d   = state_q;
    owner_d   = owner_q;
    slave_d   = slave_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    smaster_d = smaster_q;
    sslave_d  = sslave_q;
    case (state_q)
      IDLE: begin
        shift_d = '0;
        cnt_d   = '0;
        if (pend_q && !split_ext[sslave_q]) begin
          state_d = RESUME;
          owner_d = smaster_q;
          slave_d = sslave_q;
        end else if (bus.m1_request && !(pend_q && !smaster_q)) begin
          state_d = GRANT;
          owner_d = 1'b0;
        end else if (bus.m2_request && !(pend_q && smaster_q)) begin
          state_d = GRANT;
          owner_d = 1'b1;
        end
      end
      GRANT: state_d = req ? SELECT : IDLE;
      SELECT: begin
        if (!req) begin
          state_d = IDLE;
          shift_d = '0;
        end else if (cnt_q == CW'(SLAVE_LEN - 1)) begin
          state_d = bad_id ? IDLE : BUSY;
          slave_d = bad_id ? '0 : id;
          shift_d = '0;
        end else begin
          shift_d = id;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          slave_d = '0;
        end else if (split_ext[slave_q] && !pend_q) begin
          state_d   = IDLE;
          slave_d   = '0;
          pend_d    = 1'b1;
          smaster_d = owner_q;
          sslave_d  = slave_q;
        end
      end
      RESUME: begin
        state_d = BUSY;
        pend_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    g1_d = state_d != IDLE && !owner_d;
    g2_d = state_d != IDLE && owner_d;
    ab_d = state_d == GRANT || state_d == SELECT || state_d == RESUME;
    bb_d = state_d == BUSY;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      slave_q   <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      smaster_q <= 1'b0;
      sslave_q  <= '0;
      g1_q      <= 1'b0;
      g2_q      <= 1'b0;
      ab_q      <= 1'b0;
      bb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      slave_q   <= slave_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      smaster_q <= smaster_d;
      sslave_q  <= sslave_d;
      g1_q      <= g1_d;
      g2_q      <= g2_d;
      ab_q      <= ab_d;
      bb_q      <= bb_d;
    end
  end
  assign bus.m1_approval_grant = g1_q;
  assign bus.m2_approval_grant = g2_q;
  assign bus.arbitor_busy      = ab_q;
  assign bus.bus_busy          = bb_q;
  assign bus.master_sel        = owner_q;
  assign bus.slave_sel         = slave_q;
  assign bus.split_pending     = pend_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table plus hand-written sequences, scored through an expected-output queue
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  bus_arbiter_if #(.SLAVE_LEN(2), .NUM_SLAVES(3)) bus ();
  bus_arbiter #(.SLAVE_LEN(2), .NUM_SLAVES(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic       rn;
    logic [1:0] r;
    logic [1:0] s;
    logic [1:0] d;
    logic [2:0] sp;
    logic [1:0] g;
    logic       ab;
    logic       bb;
    logic       ms;
    logic [1:0] ss;
    logic       p;
  } vec_t;
  typedef struct {
    logic [7:0] exp;
    int         idx;
  } sb_t;
  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n = 0;
  function automatic vec_t mk(logic rn, logic [1:0] r, logic [1:0] s, logic [1:0] d,
                              logic [2:0] sp, logic [1:0] g, logic ab, logic bb,
                              logic ms, logic [1:0] ss, logic p);
    return {rn, r, s, d, sp, g, ab, bb, ms, ss, p};
  endfunction
  task automatic step(vec_t v);
    sb_t e;
    @(negedge clk);
    reset               = v.rn;
    bus.m1_request      = v.r[1];
    bus.m2_request      = v.r[0];
    bus.m1_slave_select = v.s[1];
    bus.m2_slave_select = v.s[0];
    bus.m1_trans_done   = v.d[1];
    bus.m2_trans_done   = v.d[0];
    bus.split_en        = v.sp;
    e.exp = {v.g, v.ab, v.bb, v.ms, v.ss, v.p};
    e.idx = n;
    sb_q.push_back(e);
    n++;
  endtask
  task automatic to_busy(logic m, logic [1:0] id, logic [2:0] sp, logic p);
    logic [1:0] r;
    logic [1:0] b1;
    logic [1:0] b0;
    r  = m ? 2'b01 : 2'b10;
    b1 = m ? {1'b0, id[1]} : {id[1], 1'b0};
    b0 = m ? {1'b0, id[0]} : {id[0], 1'b0};
    step(mk(1'b1, r, 2'b00, 2'b00, sp, r, 1'b1, 1'b0, m, 2'd0, p));
    step(mk(1'b1, r, 2'b00, 2'b00, sp, r, 1'b1, 1'b0, m, 2'd0, p));
    step(mk(1'b1, r, b1, 2'b00, sp, r, 1'b1, 1'b0, m, 2'd0, p));
    step(mk(1'b1, r, b0, 2'b00, sp, r, 1'b0, 1'b1, m, id, p));
  endtask
  always @(posedge clk) begin
    sb_t        e;
    logic [7:0] act;
    #1;
    act = {bus.m1_approval_grant, bus.m2_approval_grant, bus.arbitor_busy, bus.bus_busy,
           bus.master_sel, bus.slave_sel, bus.split_pending};
    checks += 2;
    if (act[7] && act[6]) begin
      errors++;
      $display("FAIL onehot_grant t=%0t got g1=%b g2=%b want not both", $time, act[7], act[6]);
    end
    if (act[5] && act[4]) begin
      errors++;
      $display("FAIL busy_excl t=%0t got ab=%b bb=%b want not both", $time, act[5], act[4]);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL step%0d got g1g2=%b ab=%b bb=%b ms=%b ss=%0d pend=%b want g1g2=%b ab=%b bb=%b ms=%b ss=%0d pend=%b",
                 e.idx, act[7:6], act[5], act[4], act[3], act[2:1], act[0],
                 e.exp[7:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:1], e.exp[0]);
      end
    end
  end
  initial begin
    vec_t tbl[$];
    reset = 1'b0;
    bus.m1_request = 1'b0;
    bus.m2_request = 1'b0;
    bus.m1_slave_select = 1'b0;
    bus.m2_slave_select = 1'b0;
    bus.m1_trans_done = 1'b0;
    bus.m2_trans_done = 1'b0;
    bus.split_en = 3'b000;
    tbl.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b10, 2'b10, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, 2'b10, 2'b00, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b01, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b01, 2'b00, 3'b000, 2'b01, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    foreach (tbl[i]) step(tbl[i]);
    // M1 splits on slave 3, M2 uses slave 1 meanwhile, then M1 resumes without SELECT
    to_busy(1'b0, 2'd3, 3'b000, 1'b0);
    step(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    step(mk(1'b1, 2'b11, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b11, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b11, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b11, 2'b01, 2'b00, 3'b100, 2'b01, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1));
    step(mk(1'b1, 2'b10, 2'b00, 2'b01, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1));
    step(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0));
    step(mk(1'b1, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    // split pending on slave 3: M2 selecting id 3, then id 0, is aborted after SELECT
    to_busy(1'b0, 2'd3, 3'b000, 1'b0);
    step(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b01, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1));
    // reset in BUSY with a split outstanding clears everything
    to_busy(1'b1, 2'd1, 3'b100, 1'b1);
    step(mk(1'b0, 2'b01, 2'b00, 2'b00, 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    step(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    // trans_done and split_en together: done wins, no split recorded
    to_busy(1'b0, 2'd2, 3'b000, 1'b0);
    step(mk(1'b1, 2'b00, 2'b00, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    step(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    // reset during SELECT, then normal arbitration
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    step(mk(1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
    step(mk(1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    step(mk(1'b1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    step(mk(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
